prod_accum: RTL and testbench
=============================

Name: prod_accum

Overview:
- Sequential accumulator directly downstream of the 3x3 combinational multiplier (3-bit a, 3-bit b, 6-bit product f).
- Accepts a batch of N products over a valid/ready handshake, sums them, and tracks the largest product in the batch.
- Presents the sum and the maximum on an output valid/ready handshake.
- The multiplier's f drives in_prod directly; there is no register between the two stages.

Parameters:
- PW, 6, product width; matches the 6-bit multiplier output.
- N, 8, number of products per batch; must be >= 2.
- CW, 3, counter width; equals clog2(N).
- AW, 9, sum width; equals PW+CW, so the sum cannot overflow.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  pulse that begins a batch; honoured only in IDLE
- in_valid  input  1  in_prod holds a valid product
- in_prod  input  PW  product from the multiplier
- in_ready  output  1  accumulator accepts a product this cycle
- out_valid  output  1  sum and max_prod are valid
- out_ready  input  1  downstream consumes the result
- sum  output  AW  batch sum
- max_prod  output  PW  largest product in the batch
- count  output  CW  products accepted so far in the current batch
- busy  output  1  high in ACCUM or DONE

Behaviour:
- Clock and reset:
  - One clock domain.
  - rst is asynchronous and active-high; it forces state=IDLE and sum=0, max_prod=0, count=0, out_valid=0, in_ready=0, busy=0.
  - rst asserted mid-batch discards all partial results.
- States: IDLE, ACCUM, DONE, encoded as 2 bits (IDLE=0, ACCUM=1, DONE=2).
  - Encoding 3 is illegal and returns to IDLE on the next edge.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 at an edge: clear sum, max_prod and count, then go to ACCUM.
- ACCUM:
  - in_ready=1 combinationally from state; it does not depend on in_valid.
  - A transfer is in_valid & in_ready at the rising edge. On a transfer:
    - sum <= sum + zero-extended in_prod.
    - max_prod <= in_prod when in_prod > max_prod.
    - count <= count + 1.
  - No transfer: all registers hold.
  - On the transfer that completes product N (count == N-1 before the edge), go to DONE.
    - count wraps to 0 on that edge.
    - The sum includes the final product.
  - start is ignored while in ACCUM.
- DONE:
  - out_valid=1 and in_ready=0; sum and max_prod are held stable.
  - out_ready=1 at an edge: go to IDLE. sum and max_prod keep their values until the next start.
  - start in DONE is ignored, including when out_ready is asserted in the same cycle; a new batch needs a start in IDLE.
- Latency: out_valid rises on the edge that accepts product N, so the result is visible 1 cycle after the last transfer.
- Arithmetic: unsigned; the worst case is 49*N = 392 for N=8, which is below 2^AW.
- Product value 0 is a legal transfer: count advances and sum is unchanged.

Decomposition:
- Shared package: state encodings (ST_IDLE, ST_ACCUM, ST_DONE) and the default PW, N, CW, AW constants.
- Sub-module: none required; the FSM plus datapath is small enough for one module.
- Optional wrapper p5_accum_top: instantiates the multiplier and prod_accum, with f wired to in_prod, for system tests.

Test Plan:
1. Reset: rst=1 mid-ACCUM after 3 transfers -> next cycle state IDLE, sum=0, count=0, in_ready=0, out_valid=0.
2. Full batch: start, then a=7 with b=0..7 fed back-to-back with in_valid=1 -> out_valid=1 one cycle after the 8th transfer, sum=196, max_prod=49, count=0.
3. Stalls: same batch with in_valid low every other cycle -> identical sum=196; registers hold on idle cycles; out_valid appears only after the 8th transfer.
4. Back-pressure: hold out_ready=0 for 5 cycles in DONE -> sum, max_prod and out_valid stable; in_ready=0; extra in_valid pulses are ignored.
5. Spurious start: start pulsed during ACCUM and during DONE -> no clearing, count unaffected.
6. Zeros and max: batch a=0, b=0..7 -> sum=0, max_prod=0; then a new batch with products 3,0,6,6,1,2,0,5 -> sum=23, max_prod=6.

Source files
------------

// File: rtl/prod_accum_pkg.sv
// Shared constants and state encoding for the product accumulator that sits
// behind the 3x3 multiplier.
package prod_accum_pkg;

  localparam int DEF_PW = 6;
  localparam int DEF_N  = 8;
  localparam int DEF_CW = 3;
  localparam int DEF_AW = DEF_PW + DEF_CW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/prod_accum.sv
// Batch accumulator: sums N products arriving on a valid/ready handshake, tracks
// the largest one, and holds both on an output handshake until consumed.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int PW = DEF_PW,
  parameter int N  = DEF_N,
  parameter int CW = DEF_CW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [PW-1:0] in_prod,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] sum,
  output logic [PW-1:0] max_prod,
  output logic [CW-1:0] count,
  output logic          busy
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] sum_q, sum_d;
  logic [PW-1:0] max_q, max_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sum_d   = '0;
          max_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // in_ready is a pure decode of ACCUM, so in_valid alone marks a transfer
        if (in_valid) begin
          sum_d = sum_q + AW'(in_prod);
          if (in_prod > max_q) max_d = in_prod;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);
  assign sum       = sum_q;
  assign max_prod  = max_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: expected results are queued at issue time and
// popped by an independent monitor whenever a result handshake occurs.
module tb_prod_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [5:0] in_prod;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] sum;
  logic [5:0] max_prod;
  logic [2:0] count;
  logic       busy;

  prod_accum dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_prod(in_prod),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .max_prod(max_prod), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] sum;
    logic [5:0] mx;
  } exp_t;
  typedef logic [5:0] batch_t [8];

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a result is consumed when out_valid & out_ready meet at an edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got sum %0d with empty queue", sum);
        end else begin
          e = q.pop_front();
          chk("result_sum", 32'(sum), 32'(e.sum));
          chk("result_max", 32'(max_prod), 32'(e.mx));
          chk("result_count", 32'(count), 32'd0);
        end
      end
    end
  end

  // Drives one full batch; optional idle cycles between transfers and a stray
  // start pulse in the middle of ACCUM.
  task automatic run_batch(input batch_t p, input bit stall, input bit spur);
    int rs;
    rs = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accum_in_ready", 32'(in_ready), 32'd1);
    chk("accum_count0", 32'(count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (stall && i > 0) begin
        in_valid = 1'b0;
        in_prod  = 6'd63;
        tick();
        chk("stall_count", 32'(count), 32'(i));
        chk("stall_sum", 32'(sum), 32'(rs));
        chk("stall_out_valid", 32'(out_valid), 32'd0);
      end
      in_valid = 1'b1;
      in_prod  = p[i];
      start    = spur && (i == 4);
      tick();
      start = 1'b0;
      rs += int'(p[i]);
      if (i < 7) begin
        chk("mid_count", 32'(count), 32'(i + 1));
        chk("mid_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_in_ready", 32'(in_ready), 32'd0);
        chk("done_count_wrap", 32'(count), 32'd0);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    batch_t b7, b5, bz, bm;
    int     w;
    b7 = '{6'd0, 6'd7, 6'd14, 6'd21, 6'd28, 6'd35, 6'd42, 6'd49};
    b5 = '{6'd0, 6'd5, 6'd10, 6'd15, 6'd20, 6'd25, 6'd30, 6'd35};
    bz = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    bm = '{6'd3, 6'd0, 6'd6, 6'd6, 6'd1, 6'd2, 6'd0, 6'd5};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b1;
    #12;
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Reset mid-batch after three transfers discards the partial sum
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1;
    in_prod = 6'd7;  tick();
    in_prod = 6'd14; tick();
    in_prod = 6'd21; tick();
    in_valid = 1'b0;
    chk("pre_rst_sum", 32'(sum), 32'd42);
    chk("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back full batch: a=7, b=0..7
    q.push_back('{sum: 9'd196, mx: 6'd49});
    run_batch(b7, 1'b0, 1'b0);
    tick();
    chk("after_ack_out_valid", 32'(out_valid), 32'd0);
    chk("after_ack_sum_held", 32'(sum), 32'd196);

    // Same batch with idle cycles between transfers
    q.push_back('{sum: 9'd196, mx: 6'd49});
    run_batch(b7, 1'b1, 1'b0);
    tick();

    // Back-pressure in DONE, stray in_valid and start pulses, start in ACCUM
    out_ready = 1'b0;
    q.push_back('{sum: 9'd140, mx: 6'd35});
    run_batch(b5, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_prod  = 6'd63;
      start    = (i == 2);
      tick();
      chk("bp_sum", 32'(sum), 32'd140);
      chk("bp_max", 32'(max_prod), 32'd35);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_ignored_busy", 32'(busy), 32'd0);
    tick();
    chk("idle_stays_idle", 32'(in_ready), 32'd0);
    chk("idle_sum_held", 32'(sum), 32'd140);

    // All-zero batch then a mixed batch
    q.push_back('{sum: 9'd0, mx: 6'd0});
    run_batch(bz, 1'b0, 1'b0);
    tick();
    q.push_back('{sum: 9'd23, mx: 6'd6});
    run_batch(bm, 1'b1, 1'b0);
    tick();

    w = 0;
    while (q.size() != 0 && w < 20) begin
      tick();
      w++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d results pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
